// File: rtl/ht_cmd_frontend.sv
// ============================================================================
// ht_cmd_frontend : byte-serial command assembler / request issuer for the
//                   hash-table core, with response timeout and overrun flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module ht_cmd_frontend #(
    parameter int KEY_BYTES = 1,
    parameter int VAL_BYTES = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [1:0]             req_op,
    output logic [8*KEY_BYTES-1:0] req_key,
    output logic [8*VAL_BYTES-1:0] req_val,
    input  logic                   resp_valid,
    input  logic                   resp_hit,
    input  logic [8*VAL_BYTES-1:0] resp_val,
    output logic [7:0]             status,
    output logic [8*VAL_BYTES-1:0] result
);

    localparam int KW   = 8 * KEY_BYTES;
    localparam int VW   = 8 * VAL_BYTES;
    localparam int MAXB = (KEY_BYTES > VAL_BYTES) ? KEY_BYTES : VAL_BYTES;
    localparam int BC_W = $clog2(MAXB + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_KEY   = 3'd1;
    localparam logic [2:0] S_VAL   = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_LOOKUP = 2'b10;

    localparam logic [BC_W-1:0] KEY_LAST = BC_W'(KEY_BYTES - 1);
    localparam logic [BC_W-1:0] VAL_LAST = BC_W'(VAL_BYTES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [BC_W-1:0] byte_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      last_op;
    logic [KW-1:0]   key_q;
    logic [VW-1:0]   val_q;
    logic [VW-1:0]   result_q;
    logic            done_q;
    logic            hit_q;
    logic            err_q;
    logic            ovr_q;
    logic            busy;

    logic [1:0]      new_op;
    logic            accept_op;
    logic            key_done;
    logic            val_done;
    logic            timed_out;
    logic [KW+7:0]   key_shift;
    logic [VW+7:0]   val_shift;

    assign new_op    = in_byte[7:6];
    assign accept_op = in_valid && (new_op != OP_NOP);
    assign key_done  = in_valid && (byte_cnt == KEY_LAST);
    assign val_done  = in_valid && (byte_cnt == VAL_LAST);
    assign timed_out = (to_cnt == TO_LAST);
    // First byte received ends up in the MSB after KEY_BYTES/VAL_BYTES shifts.
    assign key_shift = {key_q, in_byte};
    assign val_shift = {val_q, in_byte};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept_op) state_nxt = S_KEY;
            end
            S_KEY: begin
                if (key_done) state_nxt = (last_op == OP_INSERT) ? S_VAL : S_ISSUE;
            end
            S_VAL: begin
                if (val_done) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (resp_valid || timed_out) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy      = 1'b0;
        req_valid = 1'b0;
        case (state)
            S_KEY, S_VAL, S_WAIT: busy = 1'b1;
            S_ISSUE: begin
                busy      = 1'b1;
                req_valid = 1'b1;
            end
            default: begin
                busy      = 1'b0;
                req_valid = 1'b0;
            end
        endcase
    end

    // Datapath: byte assembly, timeout counter, status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            to_cnt   <= '0;
            last_op  <= 2'b00;
            key_q    <= '0;
            val_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_op) begin
                        last_op  <= new_op;
                        byte_cnt <= '0;
                        key_q    <= '0;
                        val_q    <= '0;
                        result_q <= '0;
                        done_q   <= 1'b0;
                        hit_q    <= 1'b0;
                        err_q    <= 1'b0;
                        ovr_q    <= 1'b0;
                    end
                end
                S_KEY: begin
                    if (in_valid) begin
                        key_q    <= key_shift[KW-1:0];
                        byte_cnt <= key_done ? '0 : byte_cnt + BC_W'(1);
                    end
                end
                S_VAL: begin
                    if (in_valid) begin
                        val_q    <= val_shift[VW-1:0];
                        byte_cnt <= val_done ? '0 : byte_cnt + BC_W'(1);
                    end
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                    if (in_valid) ovr_q <= 1'b1;
                end
                S_WAIT: begin
                    if (in_valid) ovr_q <= 1'b1;
                    // A response arriving on the timeout cycle takes priority.
                    if (resp_valid) begin
                        hit_q    <= resp_hit;
                        result_q <= (last_op == OP_LOOKUP && resp_hit) ? resp_val : '0;
                        done_q   <= 1'b1;
                    end else if (timed_out) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        hit_q  <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    byte_cnt <= '0;
                end
            endcase
        end
    end

    assign req_op  = last_op;
    assign req_key = key_q;
    assign req_val = val_q;
    assign result  = result_q;
    assign status  = {busy, done_q, hit_q, err_q, ovr_q, 1'b0, last_op};

endmodule

`default_nettype wire

// File: tb/tb_ht_cmd_frontend.sv
// Directed bench for ht_cmd_frontend: table of full transactions plus
// hand-written timeout, overrun, NOP and reset sequences.
`default_nettype none

module tb_ht_cmd_frontend;

    localparam int TO = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_key;
    logic [7:0] req_val;
    logic       resp_valid;
    logic       resp_hit;
    logic [7:0] resp_val;
    logic [7:0] status;
    logic [7:0] result;

    int tests = 0;
    int fails = 0;

    ht_cmd_frontend #(.KEY_BYTES(1), .VAL_BYTES(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_byte(in_byte), .in_valid(in_valid),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_key(req_key), .req_val(req_val),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_val(resp_val),
        .status(status), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] op;
        logic [7:0] key;
        logic [7:0] val;
        logic       hit;
        logic [7:0] rval;
        int         ready_dly;
        int         resp_dly;
        logic [7:0] exp_status;
        logic [7:0] exp_result;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic accept_req();
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
    endtask

    // Full transaction from opcode to response, checking request and final status.
    task automatic run_txn(input vec_t v, input string tag);
        logic [1:0] op;
        logic [7:0] exp_val;
        op      = v.op[7:6];
        exp_val = (op == 2'b01) ? v.val : 8'h00;
        send_byte(v.op);
        check({tag, " busy_after_op"}, status, {6'b100000, op});
        send_byte(v.key);
        if (op == 2'b01) send_byte(v.val);
        check({tag, " req_valid"}, req_valid, 1);
        check({tag, " req_fields"}, {req_op, req_key, req_val}, {op, v.key, exp_val});
        for (int i = 0; i < v.ready_dly; i++) begin
            @(negedge clk);
            check({tag, " req_held"}, {req_valid, req_key}, {1'b1, v.key});
        end
        accept_req();
        check({tag, " req_dropped"}, req_valid, 0);
        repeat (v.resp_dly) @(negedge clk);
        resp_valid = 1'b1;
        resp_hit   = v.hit;
        resp_val   = v.rval;
        @(negedge clk);
        resp_valid = 1'b0;
        check({tag, " status"}, status, v.exp_status);
        check({tag, " result"}, result, v.exp_result);
    endtask

    initial begin
        rst_n = 1'b0; in_byte = 8'h00; in_valid = 1'b0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_hit = 1'b0; resp_val = 8'h00;

        //            op     key    val    hit   rval   rdy rsp status  result
        vecs[0] = '{8'h40, 8'h2A, 8'h55, 1'b1, 8'h00, 0, 3, 8'h61, 8'h00};
        vecs[1] = '{8'hC0, 8'h2A, 8'h00, 1'b1, 8'h99, 1, 0, 8'h63, 8'h00};
        vecs[2] = '{8'h80, 8'h13, 8'h00, 1'b0, 8'hAA, 2, 1, 8'h42, 8'h00};
        vecs[3] = '{8'h7F, 8'hFF, 8'h00, 1'b0, 8'h00, 0, 2, 8'h41, 8'h00};
        vecs[4] = '{8'hC5, 8'h01, 8'h00, 1'b0, 8'h00, 0, 0, 8'h43, 8'h00};
        vecs[5] = '{8'h80, 8'h2A, 8'h00, 1'b1, 8'h55, 5, 2, 8'h62, 8'h55};

        repeat (2) @(negedge clk);
        check("reset_status", status, 8'h00);
        check("reset_outputs", {req_valid, req_op, req_key, req_val, result}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Timeout: core never responds; result from previous LOOKUP hit must clear.
        send_byte(8'h80);
        send_byte(8'h13);
        accept_req();
        repeat (TO) @(negedge clk);
        check("timeout_not_yet", status, 8'h82);
        @(negedge clk);
        check("timeout_status", status, 8'h52);
        check("timeout_result", result, 8'h00);

        // Response on the timeout cycle wins.
        send_byte(8'h80);
        send_byte(8'h21);
        accept_req();
        repeat (TO) @(negedge clk);
        resp_valid = 1'b1; resp_hit = 1'b1; resp_val = 8'h3C;
        @(negedge clk);
        resp_valid = 1'b0;
        check("race_status", status, 8'h62);
        check("race_result", result, 8'h3C);

        // Overrun: byte strobed during WAIT.
        send_byte(8'hC0);
        send_byte(8'h2A);
        accept_req();
        send_byte(8'h77);
        resp_valid = 1'b1; resp_hit = 1'b0; resp_val = 8'h00;
        @(negedge clk);
        resp_valid = 1'b0;
        check("ovr_status", status, 8'h4B);
        send_byte(8'h80);
        check("ovr_cleared", status, 8'h82);
        send_byte(8'h05);
        accept_req();
        resp_valid = 1'b1; resp_hit = 1'b0;
        @(negedge clk);
        resp_valid = 1'b0;
        check("ovr_txn_done", status, 8'h42);

        // NOP opcodes and stray response in IDLE.
        send_byte(8'h00);
        check("nop00", {status, result, 7'd0, req_valid}, {8'h42, 8'h00, 8'h00});
        send_byte(8'h3F);
        check("nop3f", {status, result, 7'd0, req_valid}, {8'h42, 8'h00, 8'h00});
        resp_valid = 1'b1; resp_hit = 1'b1; resp_val = 8'hEE;
        @(negedge clk);
        resp_valid = 1'b0;
        check("idle_resp_ignored", {status, result}, {8'h42, 8'h00});

        // Reset asserted for one cycle mid-WAIT.
        send_byte(8'h40);
        send_byte(8'h10);
        send_byte(8'h20);
        accept_req();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_wait_status", status, 8'h00);
        check("rst_wait_outputs", {req_valid, result}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(vecs[0], "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
